// File: rtl/cpu_rf_pkg.sv
// Shared constants, dump-engine state type and address helpers for the
// multi-port CPU register file.
package cpu_rf_pkg;

    localparam int RF_WIDTH     = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_NUM_REGS  = 32;
    localparam int RF_NUM_RD    = 2;
    localparam int RF_NUM_WR    = 2;
    localparam int RF_GP_IDX    = 28;
    localparam logic [RF_WIDTH-1:0] RF_GP_INIT = 32'h0000_1800;
    localparam int RF_SP_IDX    = 29;
    localparam logic [RF_WIDTH-1:0] RF_SP_INIT = 32'h0000_2ffe;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_SCAN = 2'd1,
        DS_DONE = 2'd2
    } dump_state_t;

    // An address names a real, writable register: nonzero and below the count.
    function automatic logic rf_addr_ok(input int a, input int n);
        return (a != 0) && (a < n);
    endfunction

    // Extract field k of a packed port bus (up to 32 bits wide per field).
    function automatic int rf_field(input logic [1023:0] bus, input int k, input int w);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < w) v[b] = bus[k*w + b];
        end
        return int'(v);
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks indices 0..NUM_REGS-1 over a valid/ready handshake and
// emits a single done pulse after the final word is accepted.
module regfile_dump_fsm
    import cpu_rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    dump_state_t       w_next;
    logic [ADDR_W-1:0] r_idx;
    logic              w_last_hs;

    assign w_last_hs = (r_state == DS_SCAN) && i_ready && (r_idx == LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= DS_IDLE;
        else         r_state <= w_next;
    end

    // Next-state: start only honoured from IDLE; DONE lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            DS_IDLE: if (i_start)   w_next = DS_SCAN;
            DS_SCAN: if (w_last_hs) w_next = DS_DONE;
            DS_DONE:                w_next = DS_IDLE;
            default:                w_next = DS_IDLE;
        endcase
    end

    // Index advances per accepted word; cleared outside SCAN so it only wraps via exit
    always_ff @(posedge i_clk) begin
        if (i_reset)                              r_idx <= '0;
        else if (r_state != DS_SCAN || w_last_hs) r_idx <= '0;
        else if (i_ready)                         r_idx <= r_idx + 1'b1;
    end

    // Outputs decoded from state
    always_comb begin
        o_valid = (r_state == DS_SCAN);
        o_busy  = (r_state != DS_IDLE);
        o_done  = (r_state == DS_DONE);
        o_idx   = r_idx;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational reads with write bypass, prioritised
// synchronous writes (highest port wins), R0 hardwired to zero, plus dump engine.
module regfile_mp
    import cpu_rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter int GP_IDX   = RF_GP_IDX,
    parameter logic [WIDTH-1:0] GP_INIT = RF_GP_INIT,
    parameter int SP_IDX   = RF_SP_IDX,
    parameter logic [WIDTH-1:0] SP_INIT = RF_SP_INIT
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR*WIDTH-1:0]  i_wdata,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*WIDTH-1:0]  o_rdata,
    input  logic                     i_dump_start,
    output logic                     o_dump_valid,
    input  logic                     i_dump_ready,
    output logic [ADDR_W-1:0]        o_dump_idx,
    output logic [WIDTH-1:0]         o_dump_data,
    output logic                     o_dump_busy,
    output logic                     o_dump_done
);

    logic [WIDTH-1:0]  r_regs [NUM_REGS];
    logic [ADDR_W-1:0] w_dump_idx;

    // Storage: ports applied in ascending order so the highest-numbered port wins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_regs                  <= '{default: '0};
            r_regs[ADDR_W'(GP_IDX)] <= GP_INIT;
            r_regs[ADDR_W'(SP_IDX)] <= SP_INIT;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_we[k] && rf_addr_ok(32'(i_waddr[k*ADDR_W +: ADDR_W]), NUM_REGS))
                    r_regs[i_waddr[k*ADDR_W +: ADDR_W]] <= i_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [WIDTH-1:0]  w_rd;
        assign w_ra = i_raddr[j*ADDR_W +: ADDR_W];

        // Read: zero for R0/out-of-range, else stored value overridden by the
        // highest-numbered enabled write to the same address this cycle
        always_comb begin
            w_rd = '0;
            if (rf_addr_ok(32'(w_ra), NUM_REGS)) begin
                w_rd = r_regs[w_ra];
                for (int k = 0; k < NUM_WR; k++) begin
                    if (i_we[k] && (i_waddr[k*ADDR_W +: ADDR_W] == w_ra))
                        w_rd = i_wdata[k*WIDTH +: WIDTH];
                end
            end
        end

        assign o_rdata[j*WIDTH +: WIDTH] = w_rd;
    end

    regfile_dump_fsm #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dump (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_dump_start),
        .i_ready (i_dump_ready),
        .o_valid (o_dump_valid),
        .o_idx   (w_dump_idx),
        .o_busy  (o_dump_busy),
        .o_done  (o_dump_done)
    );

    // Dump shows the stored value only; same-cycle writes appear a cycle later
    assign o_dump_idx  = w_dump_idx;
    assign o_dump_data = r_regs[w_dump_idx];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_regfile_mp;

    localparam int W   = 32;
    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NWR-1:0]    we;
    logic [NWR*AW-1:0] waddr;
    logic [NWR*W-1:0]  wdata;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*W-1:0]  rdata;
    logic              dump_start, dump_valid, dump_ready, dump_busy, dump_done;
    logic [AW-1:0]     dump_idx;
    logic [W-1:0]      dump_data;

    int errors = 0;
    int checks = 0;

    regfile_mp dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_we         (we),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .i_raddr      (raddr),
        .o_rdata      (rdata),
        .i_dump_start (dump_start),
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_idx   (dump_idx),
        .o_dump_data  (dump_data),
        .o_dump_busy  (dump_busy),
        .o_dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos: -1 idle, 0..NR-1 word being offered, NR = done cycle
    logic [W-1:0] m_regs [NR];
    int           m_pos  = -1;
    bit           m_live = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_regs[28] = 32'h0000_1800;
            m_regs[29] = 32'h0000_2ffe;
            m_pos  = -1;
            m_live = 1;
        end else if (m_live) begin
            if (m_pos == NR)    m_pos = -1;
            else if (m_pos >= 0) begin
                if (dump_ready) m_pos = m_pos + 1;
            end else if (dump_start) m_pos = 0;
            for (int k = 0; k < NWR; k++) begin
                int a;
                a = int'(waddr[k*AW +: AW]);
                if (we[k] && a != 0 && a < NR) m_regs[a] = wdata[k*W +: W];
            end
        end
    end

    function automatic logic [W-1:0] exp_rd(input int a);
        logic [W-1:0] v;
        if (a == 0 || a >= NR) return '0;
        v = m_regs[a];
        for (int k = 0; k < NWR; k++)
            if (we[k] && int'(waddr[k*AW +: AW]) == a) v = wdata[k*W +: W];
        return v;
    endfunction

    // Compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_live && !reset) begin
            for (int j = 0; j < NRD; j++)
                chk("rdata", rdata[j*W +: W], exp_rd(int'(raddr[j*AW +: AW])));
            chk("valid", 32'(dump_valid), 32'(m_pos >= 0 && m_pos < NR));
            chk("busy",  32'(dump_busy),  32'(m_pos >= 0));
            chk("done",  32'(dump_done),  32'(m_pos == NR));
            if (m_pos >= 0 && m_pos < NR) begin
                chk("dump_idx",  32'(dump_idx), 32'(m_pos));
                chk("dump_data", dump_data, m_regs[m_pos]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input int a, input logic [W-1:0] d);
        we[k]           = 1'b1;
        waddr[k*AW +: AW] = AW'(a);
        wdata[k*W +: W]   = d;
    endtask

    task automatic rd(input int j, input int a);
        raddr[j*AW +: AW] = AW'(a);
    endtask

    initial begin
        int cnt, dn;
        bit fin;
        reset = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
        dump_start = 1'b0; dump_ready = 1'b0;

        // 1. reset
        tick();
        reset = 1'b0;
        rd(0, 28); rd(1, 29);
        #1;
        chk("rst_gp", rdata[0 +: W], 32'h0000_1800);
        chk("rst_sp", rdata[W +: W], 32'h0000_2ffe);
        chk("rst_busy", 32'(dump_busy), 0);
        chk("rst_valid", 32'(dump_valid), 0);
        chk("model_gp", m_regs[28], 32'h0000_1800);
        rd(0, 3);
        #1;
        chk("rst_r3", rdata[0 +: W], 0);
        tick();

        // 2. write + same-cycle bypass
        wr(0, 5, 32'hDEAD_BEEF); rd(0, 5);
        #1;
        chk("bypass_r5", rdata[0 +: W], 32'hDEAD_BEEF);
        tick();
        we = '0;
        #1;
        chk("stored_r5", rdata[0 +: W], 32'hDEAD_BEEF);
        tick();

        // 3. collision and R0
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(1, 7);
        #1;
        chk("coll_bypass", rdata[W +: W], 32'h22);
        tick();
        we = '0;
        #1;
        chk("coll_stored", rdata[W +: W], 32'h22);
        wr(0, 0, 32'hFFFF_FFFF); rd(0, 0);
        #1;
        chk("r0_bypass", rdata[0 +: W], 0);
        tick();
        we = '0;
        #1;
        chk("r0_stored", rdata[0 +: W], 0);
        tick();

        // 4. preload Rn = n*0x10, dump with backpressure
        for (int n = 1; n < NR; n += 2) begin
            we = '0;
            wr(0, n, 32'(n * 16));
            if (n + 1 < NR) wr(1, n + 1, 32'((n + 1) * 16));
            tick();
        end
        we = '0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_idx", 32'(dump_idx), 0);
            chk("hold_valid", 32'(dump_valid), 1);
            tick();
        end
        dump_ready = 1'b1;
        cnt = 0; dn = 0; fin = 0;
        for (int c = 0; c < 80 && !fin; c++) begin
            #1;
            if (dump_valid) begin
                chk("dump4_idx", 32'(dump_idx), 32'(cnt));
                chk("dump4_data", dump_data, 32'(cnt * 16));
                cnt++;
            end
            if (dump_done) begin dn++; fin = 1; end
            tick();
        end
        chk("dump4_finished", 32'(fin), 1);
        chk("dump4_words", 32'(cnt), 32);
        chk("dump4_done_pulses", 32'(dn), 1);
        #1;
        chk("dump4_done_clear", 32'(dump_done), 0);
        chk("dump4_idle", 32'(dump_busy), 0);
        dump_ready = 1'b0;
        tick();

        // 5. write landing on the held dump index
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (4) tick();
        dump_ready = 1'b0;
        #1;
        chk("d5_idx", 32'(dump_idx), 4);
        wr(0, 4, 32'h0000_ABCD);
        tick();
        we = '0;
        #1;
        chk("d5_idx_hold", 32'(dump_idx), 4);
        chk("d5_data", dump_data, 32'h0000_ABCD);
        dump_ready = 1'b1;
        #1;
        chk("d5_capture", dump_data, 32'h0000_ABCD);
        tick();
        for (int c = 0; c < 60 && dump_busy; c++) tick();
        chk("d5_finished", 32'(dump_busy), 0);
        dump_ready = 1'b0;
        tick();

        // 6. ignored restart, then mid-dump reset
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        tick(); tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        #1;
        chk("d6_no_restart", 32'(dump_idx), 3);
        repeat (7) tick();
        #1;
        chk("d6_idx10", 32'(dump_idx), 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dump_ready = 1'b0;
        rd(0, 5); rd(1, 28);
        #1;
        chk("d6_busy", 32'(dump_busy), 0);
        chk("d6_valid", 32'(dump_valid), 0);
        chk("d6_done", 32'(dump_done), 0);
        chk("d6_r5", rdata[0 +: W], 0);
        chk("d6_gp", rdata[W +: W], 32'h0000_1800);
        repeat (3) begin
            tick();
            chk("d6_no_done", 32'(dump_done), 0);
        end

        // 7. randomized traffic, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            dump_start = ($urandom_range(0, 19) == 0);
            dump_ready = $urandom_range(0, 1) != 0;
            for (int k = 0; k < NWR; k++) begin
                we[k] = $urandom_range(0, 2) != 0;
                waddr[k*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                                 : AW'($urandom_range(0, NR - 1));
                wdata[k*W +: W] = $urandom;
            end
            for (int j = 0; j < NRD; j++)
                raddr[j*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                                 : AW'($urandom_range(0, NR - 1));
            tick();
        end
        reset = 1'b0; we = '0; dump_start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
